// File: rtl/div_seq.sv
// div_seq: sequential restoring divider that sequences {remainder, quotient} writes into HI/LO.
// Ports: clk, reset (sync, active-high); start/dividend/divisor request a divide (sampled in IDLE);
// busy is high in RUN and DONE; done and hilo_we pulse for one cycle in DONE;
// div_ans = {rem, quot} and div_by_zero hold until the next result is loaded.
// DIV_SIGNED_EN adds signed_op for signed division with sign fixup on the edge entering DONE.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
`ifdef DIV_SIGNED_EN
  input  logic               signed_op,
`endif
  output logic               busy,
  output logic               done,
  output logic               hilo_we,
  output logic [2*WIDTH-1:0] div_ans,
  output logic               div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;
  stateT state, nextState;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] remR, quotR, divR;
  logic [WIDTH:0] t;
  logic ge;
  logic [WIDTH-1:0] stepRem, stepQuot, resRem, resQuot, aMag, bMag;
  logic accept;
`ifdef DIV_SIGNED_EN
  logic aNeg, bNeg, negQ, negR;
`endif
  always_comb begin
    accept = state == IDLE && start;
    t = {remR, quotR[WIDTH-1]};
    ge = t >= {1'b0, divR};
    // t < divisor implies t[WIDTH] is clear, so WIDTH bits always hold the remainder
    stepRem = ge ? WIDTH'(t - {1'b0, divR}) : t[WIDTH-1:0];
    stepQuot = (quotR << 1) | WIDTH'(ge);
`ifdef DIV_SIGNED_EN
    aNeg = signed_op & dividend[WIDTH-1];
    bNeg = signed_op & divisor[WIDTH-1];
    aMag = aNeg ? -dividend : dividend;
    bMag = bNeg ? -divisor : divisor;
    resQuot = negQ ? -stepQuot : stepQuot;
    resRem = negR ? -stepRem : stepRem;
`else
    aMag = dividend;
    bMag = divisor;
    resQuot = stepQuot;
    resRem = stepRem;
`endif
    nextState = state == IDLE ? (start ? (divisor == '0 ? DONE : RUN) : IDLE)
              : state == RUN  ? (cnt == '0 ? DONE : RUN)
              : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      remR <= '0;
      quotR <= '0;
      divR <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      hilo_we <= 1'b0;
      div_ans <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      negQ <= 1'b0;
      negR <= 1'b0;
`endif
    end else begin
      state <= nextState;
      busy <= nextState != IDLE;
      done <= nextState == DONE;
      hilo_we <= nextState == DONE;
      if (accept) begin
        remR <= '0;
        quotR <= aMag;
        divR <= bMag;
        cnt <= CW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
        negQ <= aNeg ^ bNeg;
        negR <= aNeg;
`endif
        // zero divisor skips RUN, so the result is loaded straight from the raw operands
        if (divisor == '0) begin
          div_ans <= {dividend, {WIDTH{1'b1}}};
          div_by_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        remR <= stepRem;
        quotR <= stepQuot;
        cnt <= cnt == '0 ? cnt : cnt - 1'b1;
        if (cnt == '0) begin
          div_ans <= {resRem, resQuot};
          div_by_zero <= 1'b0;
        end
      end
    end
  end
endmodule
